// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed, byte-masked data memory.
// Byte/half/word requests become one or two word accesses; load data is merged and extended.
module lsu_mem_master #(
    parameter int REG_SIZE         = 32,
    parameter bit MISALIGNED_SPLIT = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [REG_SIZE-1:0] req_addr_i,
    input  logic [REG_SIZE-1:0] req_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [REG_SIZE-1:0] rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                mem_cs_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_mask_o,
    output logic [REG_SIZE-1:0] mem_addr_o,
    output logic [REG_SIZE-1:0] mem_wdata_o,
    input  logic [REG_SIZE-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state;
    logic        we;
    logic        uns;
    logic        split;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [29:0] word;
    logic [3:0]  lanes_hi;
    logic [31:0] wdata;
    logic [31:0] lo;
    logic [31:0] hi;

    function automatic logic [7:0] lane_bits(input logic [1:0] sz, input logic [1:0] ofs);
        logic [7:0] base;
        case (sz)
            2'b00:   base = 8'b0000_0001;
            2'b01:   base = 8'b0000_0011;
            default: base = 8'b0000_1111;
        endcase
        return base << ofs;
    endfunction

    // Shift the two captured words down to the addressed byte, then truncate and extend.
    function automatic logic [31:0] load_value(input logic [31:0] hi_w, input logic [31:0] lo_w,
                                               input logic [1:0] ofs, input logic [1:0] sz,
                                               input logic zext);
        logic [63:0] merged;
        merged = {hi_w, lo_w} >> {ofs, 3'b000};
        case (sz)
            2'b00:   return zext ? {24'b0, merged[7:0]}  : {{24{merged[7]}}, merged[7:0]};
            2'b01:   return zext ? {16'b0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
            default: return merged[31:0];
        endcase
    endfunction

    logic [1:0] in_off;
    logic [7:0] in_lanes;
    logic       in_split;
    logic       in_err;

    assign in_off   = req_addr_i[1:0];
    assign in_lanes = lane_bits(req_size_i, in_off);
    assign in_split = |in_lanes[7:4];
    assign in_err   = (req_size_i == 2'b11) || (in_split && !MISALIGNED_SPLIT);

    // NOTE: every output is registered and assigned with <= so all of them change together on
    //       the state transition; reset also clears lo/hi so an aborted access leaks no data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            we          <= 1'b0;
            uns         <= 1'b0;
            split       <= 1'b0;
            size        <= 2'b00;
            off         <= 2'b00;
            word        <= '0;
            lanes_hi    <= '0;
            wdata       <= '0;
            lo          <= '0;
            hi          <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            mem_cs_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_mask_o  <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we          <= req_we_i;
                        uns         <= req_unsigned_i;
                        size        <= req_size_i;
                        off         <= in_off;
                        word        <= req_addr_i[31:2];
                        wdata       <= req_wdata_i;
                        lanes_hi    <= in_lanes[7:4];
                        split       <= in_split;
                        lo          <= '0;
                        hi          <= '0;
                        req_ready_o <= 1'b0;
                        if (in_err) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state       <= ACC0;
                            mem_cs_o    <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_addr_o  <= {2'b00, req_addr_i[31:2]};
                            mem_mask_o  <= in_lanes[3:0];
                            mem_wdata_o <= req_wdata_i << {in_off, 3'b000};
                        end
                    end
                end
                ACC0: begin
                    if (!we) lo <= mem_rdata_i;
                    if (split) begin
                        state       <= ACC1;
                        mem_addr_o  <= {2'b00, word + 30'd1};
                        mem_mask_o  <= lanes_hi;
                        mem_wdata_o <= wdata >> (6'd32 - {1'b0, off, 3'b000});
                    end else begin
                        state       <= RESP;
                        mem_cs_o    <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_mask_o  <= '0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= we ? '0 : load_value(hi, mem_rdata_i, off, size, uns);
                    end
                end
                ACC1: begin
                    if (!we) hi <= mem_rdata_i;
                    state       <= RESP;
                    mem_cs_o    <= 1'b0;
                    mem_we_o    <= 1'b0;
                    mem_mask_o  <= '0;
                    mem_addr_o  <= '0;
                    mem_wdata_o <= '0;
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= we ? '0 : load_value(mem_rdata_i, lo, off, size, uns);
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= '0;
                        req_ready_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed, byte-masked data memory from the execute stage.
- Accepts one byte, half or word request per handshake and converts the byte address into a word index, a byte mask and lane-shifted write data.
- Splits misaligned accesses that cross a word boundary into two word accesses.
- Merges and sign/zero-extends load data before returning it on a response handshake.

Parameters:
- REG_SIZE, 32, data and address width; only 32 is supported.
- MISALIGNED_SPLIT, 1, 1 = boundary-crossing access split into two accesses; 0 = respond with rsp_err_o=1 and make no memory access.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when high together with req_valid_i
- req_we_i  input  1  1 = store, 0 = load
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  input  1  load zero-extend (1) or sign-extend (0)
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data, right-aligned
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors
- rsp_err_o  output  1  illegal size, or misaligned access with MISALIGNED_SPLIT=0
- mem_cs_o  output  1  memory select
- mem_we_o  output  1  memory write enable
- mem_mask_o  output  4  byte lane enables
- mem_addr_o  output  32  word index, zero-extended byte_addr[31:2]
- mem_wdata_o  output  32  lane-aligned write data
- mem_rdata_i  input  32  combinational read data at mem_addr_o

Behaviour:
- Reset (rst_i): asynchronous, active-high, clock clk_i. State goes to IDLE. All outputs are 0 except req_ready_o=1. Latched request and read buffers are cleared.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready_o=1; all mem_* outputs are 0.
  - On req_valid_i: latch the request and compute off=addr[1:0] and n = 1/2/4 bytes.
  - Set split = (off+n>4).
  - Go to RESP with err=1 if size=11, or if split and MISALIGNED_SPLIT=0. Otherwise go to ACC0.
- ACC0 (one cycle):
  - mem_cs_o=1, mem_we_o=we, mem_addr_o=addr[31:2].
  - lanes = ((1<<n)-1)<<off, an 8-bit value; mem_mask_o = lanes[3:0].
  - mem_wdata_o = wdata<<(8*off).
  - Loads capture mem_rdata_i into lo at the clock edge.
  - Go to ACC1 if split, else RESP.
- ACC1 (one cycle):
  - mem_cs_o=1, mem_addr_o=addr[31:2]+1, 30-bit wrap so 0x3FFFFFFF+1 = 0.
  - mem_mask_o = lanes[7:4]; mem_wdata_o = wdata>>(8*(4-off)).
  - Loads capture hi. Go to RESP.
- RESP:
  - rsp_valid_o=1 and held stable until rsp_ready_i; all mem_* are 0; req_ready_o=0.
  - Load data = ({hi,lo}>>(8*off)) truncated to n bytes, then sign- or zero-extended to 32 bits.
  - On rsp_ready_i: go to IDLE.
- req_ready_o=1 only in IDLE. No new request is accepted in the RESP cycle where rsp_ready_i is seen. Throughput is therefore one access per 3 or 4 cycles.
- Latency from the acceptance edge to rsp_valid_o:
  - aligned or non-crossing: 2 cycles
  - split: 3 cycles
  - error: 1 cycle
- Non-crossing misaligned accesses, e.g. a half at off=1, use a single access.
- Store data outside the masked lanes is don't-care; the memory only writes masked lanes.
- Inputs are sampled only at the acceptance edge; later changes to req_* have no effect.
- Reset mid-operation aborts with no response. A write already committed in ACC0 is not undone.

Test Plan:
- Aligned word store: addr 0x100, data 0xDEADBEEF -> ACC0 with mem_addr_o=0x40, mask=1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, rdata=0.
- Byte load, signed then unsigned: addr 0x103, memory word 0x80xxxxxx -> mask=1000; signed rdata=0xFFFFFF80, unsigned rdata=0x00000080.
- Split word load: addr 0x0FE, mem[0x3F]=0x44332211, mem[0x40]=0x88776655 -> accesses at 0x3F mask=1100 and 0x40 mask=0011; rdata=0x66554433 at 3 cycles.
- Split half store: addr 0x7, data 0x0000ABCD -> word 1 mask=1000 wdata[31:24]=0xCD, then word 2 mask=0001 wdata[7:0]=0xAB.
- Illegal size 11, then MISALIGNED_SPLIT=0 with a word load at addr 0x2 -> no mem_cs_o pulse; rsp_err_o=1 one cycle after accept.
- Backpressure and reset:
  - hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0;
  - assert rst_i during ACC1 -> immediate IDLE, no response, req_ready_o=1.
